sobel_window_gen: RTL and testbench

//  Upstream feeder for the Sobel convolution stage. Accepts a raster pixel stream (one 8-bit pixel/beat),

---
 rtl/sobel_window_gen_if.sv | 24 ++
 rtl/sobel_window_gen.sv | 163 ++++++++++++++++
 tb/tb_sobel_window_gen.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_gen_if.sv
// Pixel stream into the window generator, 3x3 window stream and line-done pulse out.
interface sobel_window_gen_if;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_intr
  );

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_intr
  );
endinterface

// File: rtl/sobel_window_gen.sv
// 3x3 window generator over four rotating line buffers; window registered 1 cycle after read issue.
// Writes are never stalled; the source paces itself on the per-line o_intr pulse.
module sobel_window_gen #(
  parameter int IMG_WIDTH = 512
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sobel_window_gen_if.slave  pix
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int CNT_W = $clog2(4 * IMG_WIDTH + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] THREE_LINES = CNT_W'(3 * IMG_WIDTH);

  typedef enum logic {
    IDLE,
    RD
  } state_t;

  logic [7:0]       lb [4][IMG_WIDTH];
  logic [COL_W-1:0] wr_col;
  logic [1:0]       wr_line;
  logic [COL_W-1:0] rd_col;
  logic [1:0]       rd_line;
  logic [CNT_W-1:0] pix_cnt;
  state_t           state;
  state_t           state_nxt;
  logic             wr_en;
  logic             rd_en;
  logic             rd_last;
  logic [COL_W-1:0] col_sel [3];
  logic [1:0]       line_sel [3];
  logic [71:0]      win;
  logic [71:0]      win_q;
  logic             win_vld_q;
  logic             intr_q;

  assign wr_en = pix.i_pixel_data_valid;

  // Line-buffer storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      lb[wr_line][wr_col] <= pix.i_pixel_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_col  <= '0;
      wr_line <= '0;
    end else if (wr_en) begin
      if (wr_col == LAST_COL) begin
        wr_col  <= '0;
        wr_line <= wr_line + 2'd1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  // Count of written-but-unread columns; a burst needs three full lines ahead.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix_cnt <= '0;
    end else if (wr_en && !rd_en) begin
      pix_cnt <= pix_cnt + 1'b1;
    end else if (!wr_en && rd_en) begin
      pix_cnt <= pix_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        if (pix_cnt >= THREE_LINES) begin
          state_nxt = RD;
        end
      end
      RD: begin
        rd_en = 1'b1;
        if (rd_col == LAST_COL) begin
          rd_last   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_col  <= '0;
      rd_line <= '0;
    end else if (rd_en) begin
      if (rd_last) begin
        rd_col  <= '0;
        rd_line <= rd_line + 2'd1;
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  // Right-edge columns replicate the last pixel of the line.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      if (int'(rd_col) + k > IMG_WIDTH - 1) begin
        col_sel[k] = LAST_COL;
      end else begin
        col_sel[k] = rd_col + COL_W'(k);
      end
    end
    for (int r = 0; r < 3; r++) begin
      line_sel[r] = rd_line + 2'(r);
    end
  end

  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        win[8*(3*r+k) +: 8] = lb[line_sel[r]][col_sel[k]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_q     <= '0;
      win_vld_q <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      win_vld_q <= rd_en;
      intr_q    <= rd_last;
      if (rd_en) begin
        win_q <= win;
      end
    end
  end

  assign pix.o_pixel_data       = win_q;
  assign pix.o_pixel_data_valid = win_vld_q;
  assign pix.o_intr             = intr_q;

  a_cnt_bound : assert property (@(posedge i_clk) disable iff (i_rst)
    pix_cnt <= CNT_W'(4 * IMG_WIDTH));

  a_intr_with_vld : assert property (@(posedge i_clk) disable iff (i_rst)
    intr_q |-> win_vld_q);

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized bench for sobel_window_gen: windows are predicted from the written pixel history
// (burst b uses source lines b..b+2, columns clamped at the right edge).
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int MAX_LINES = 16;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  sobel_window_gen_if pif ();

  sobel_window_gen #(.IMG_WIDTH(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .pix   (pif.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] src [MAX_LINES][W];
  int n_wr, mon_burst, mon_col, n_vld, n_intr, cnt_max;
  logic [71:0] first_win, last_win;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [71:0] exp_win(input int b, input int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        int col;
        col = (c + k > W - 1) ? W - 1 : c + k;
        w[8*(3*r+k) +: 8] = src[(b + r) % MAX_LINES][col % W];
      end
    end
    return w;
  endfunction

  // Output monitor: every valid window is compared with the model.
  always @(negedge i_clk) begin
    if (int'(dut.pix_cnt) > cnt_max) cnt_max = int'(dut.pix_cnt);
    if (pif.o_pixel_data_valid === 1'b1) begin
      if (mon_col == 0) check("burst_src_ready", 72'(n_wr >= (mon_burst + 3) * W), 72'(1));
      check("window", pif.o_pixel_data, exp_win(mon_burst, mon_col));
      if (mon_burst == 0 && mon_col == 0) first_win = pif.o_pixel_data;
      if (mon_col == W - 1) last_win = pif.o_pixel_data;
      mon_col++;
      n_vld++;
    end else if (mon_col > 0 && mon_col < W) begin
      check("run_continuous", 72'(pif.o_pixel_data_valid), 72'(1));
    end
    if (pif.o_intr === 1'b1) begin
      check("intr_after_run", 72'(mon_col), 72'(W));
      mon_col = 0;
      mon_burst++;
      n_intr++;
    end
  end

  task automatic clear_model();
    n_wr = 0; mon_burst = 0; mon_col = 0; n_vld = 0; n_intr = 0; cnt_max = 0;
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    pif.i_pixel_data_valid = 1'b0;
    repeat (cycles) @(posedge i_clk);
    #1;
    clear_model();
    i_rst = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    pif.i_pixel_data = d;
    pif.i_pixel_data_valid = 1'b1;
    if (n_wr < MAX_LINES * W) src[n_wr / W][n_wr % W] = d;
    @(posedge i_clk);
    #1;
    n_wr++;
    pif.i_pixel_data_valid = 1'b0;
  endtask

  task automatic push_line(input int line, input bit rnd, input bit gaps);
    for (int c = 0; c < W; c++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      push(rnd ? 8'($urandom) : 8'(line * 16 + c));
    end
  endtask

  initial begin
    int lat;
    bit hit;
    i_rst = 1'b1;
    pif.i_pixel_data = '0;
    pif.i_pixel_data_valid = 1'b0;
    clear_model();

    // Reset state, then a partial fill that must not produce output.
    do_reset(2);
    check("rst_data", pif.o_pixel_data, 72'(0));
    check("rst_vld", 72'(pif.o_pixel_data_valid), 72'(0));
    check("rst_intr", 72'(pif.o_intr), 72'(0));
    for (int p = 0; p < 10; p++) push(8'((p / W) * 16 + p % W));
    idle(6);
    check("partial_vld_cnt", 72'(n_vld), 72'(0));
    check("partial_intr_cnt", 72'(n_intr), 72'(0));
    check("partial_data", pif.o_pixel_data, 72'(0));

    // First burst: latency, first and last windows, framing.
    do_reset(1);
    for (int l = 0; l < 3; l++) push_line(l, 1'b0, 1'b0);
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge i_clk);
      if (pif.o_pixel_data_valid === 1'b1) lat = k;
    end
    check("first_vld_latency", 72'(lat >= 0 && lat <= 3), 72'(1));
    idle(14);
    check("first_window", first_win, 72'h22_21_20_12_11_10_02_01_00);
    check("eighth_window", last_win, 72'h27_27_27_17_17_17_07_07_07);
    check("burst0_vld_cnt", 72'(n_vld), 72'(W));
    check("burst0_intr_cnt", 72'(n_intr), 72'(1));

    // Line 3 trickles in; nothing may come out until it is complete.
    for (int c = 0; c < W - 1; c++) begin
      push(8'(3 * 16 + c));
      idle(2);
    end
    check("no_early_vld", 72'(n_vld), 72'(W));
    push(8'(3 * 16 + W - 1));
    idle(15);
    check("burst1_intr_cnt", 72'(n_intr), 72'(2));
    check("burst1_vld_cnt", 72'(n_vld), 72'(2 * W));

    // Seven lines back-to-back: buffer rotation and wrap.
    do_reset(1);
    for (int l = 0; l < 7; l++) push_line(l, 1'b0, 1'b0);
    idle(40);
    check("stream7_intr_cnt", 72'(n_intr), 72'(5));
    check("stream7_vld_cnt", 72'(n_vld), 72'(5 * W));
    check("stream7_cnt_max", 72'(cnt_max <= 4 * W), 72'(1));

    // Random pixels with random input gaps, overlapping reads and writes.
    do_reset(1);
    for (int l = 0; l < 12; l++) push_line(l, 1'b1, 1'b1);
    idle(60);
    check("rand_intr_cnt", 72'(n_intr), 72'(10));
    check("rand_vld_cnt", 72'(n_vld), 72'(10 * W));
    check("rand_cnt_max", 72'(cnt_max <= 4 * W), 72'(1));

    // Reset in the middle of a burst, then refill with fresh data.
    do_reset(1);
    for (int l = 0; l < 3; l++) push_line(l, 1'b0, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge i_clk);
      #1;
      if (mon_col == 4) hit = 1'b1;
    end
    check("abort_at_4th_vld", 72'(hit), 72'(1));
    do_reset(1);
    check("abort_vld_low", 72'(pif.o_pixel_data_valid), 72'(0));
    check("abort_intr_low", 72'(pif.o_intr), 72'(0));
    idle(12);
    check("abort_no_vld", 72'(n_vld), 72'(0));
    check("abort_no_intr", 72'(n_intr), 72'(0));
    for (int l = 0; l < 3; l++) push_line(l, 1'b1, 1'b0);
    idle(15);
    check("refill_first_window", first_win, exp_win(0, 0));
    check("refill_vld_cnt", 72'(n_vld), 72'(W));
    check("refill_intr_cnt", 72'(n_intr), 72'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
